// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared widths, action codes, FSM states and command decode for the sprite attribute controller
package sprite_pkg;

  localparam int ATTR_W     = 14;
  localparam int NUM_ATTR   = 8;
  localparam int SPRITE_W   = 8;
  localparam int ATTR_IDX_W = $clog2(NUM_ATTR);

  localparam logic [3:0] ACT_CLEAR  = 4'd8;
  localparam logic [3:0] ACT_MOVE_X = 4'd9;
  localparam logic [3:0] ACT_MOVE_Y = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RMW_WR,
    ST_CLEAR,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_WRITE,
    OP_READ,
    OP_CLEAR,
    OP_MOVE,
    OP_NOP
  } op_t;

  // Write wins when both strobes are set; unknown commands become no-ops.
  function automatic op_t decode_op(input logic we, input logic [3:0] action);
    op_t op;
    if (!action[3]) begin
      op = we ? OP_WRITE : OP_READ;
    end else if (we && action == ACT_CLEAR) begin
      op = OP_CLEAR;
    end else if (we && (action == ACT_MOVE_X || action == ACT_MOVE_Y)) begin
      op = OP_MOVE;
    end else begin
      op = OP_NOP;
    end
    return op;
  endfunction

endpackage

// File: rtl/sprite_attr_ram.sv
// rtl/sprite_attr_ram.sv - single-port attribute storage with one-cycle synchronous read
module sprite_attr_ram #(
  parameter int ATTR_W = 14,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ATTR_W-1:0] wdata,
  output logic [ATTR_W-1:0] rdata
);

  logic [ATTR_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Contents are deliberately not reset; software clears sprites explicitly.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/sprite_mem_ctrl.sv
// rtl/sprite_mem_ctrl.sv - arbitrates CPU commands and renderer reads onto the sprite attribute RAM
module sprite_mem_ctrl #(
  parameter int ATTR_W   = sprite_pkg::ATTR_W,
  parameter int NUM_ATTR = sprite_pkg::NUM_ATTR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [3:0]        cpu_action,
  input  logic [7:0]        cpu_addr,
  input  logic [ATTR_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic [31:0]       cpu_rdata,
  input  logic              ren_req,
  input  logic [7:0]        ren_addr,
  input  logic [2:0]        ren_attr,
  output logic              ren_gnt,
  output logic              ren_valid,
  output logic [ATTR_W-1:0] ren_rdata
);

  import sprite_pkg::*;

  localparam int IDX_W  = $clog2(NUM_ATTR);
  localparam int ADDR_W = 8 + IDX_W;

  state_t            state, state_nxt;
  logic              pend_valid;
  op_t               pend_op;
  logic [7:0]        pend_addr;
  logic [IDX_W-1:0]  pend_attr;
  logic [ATTR_W-1:0] pend_wdata;
  logic              last_ren;
  logic              out_of_reset;
  logic [IDX_W-1:0]  clr_cnt;
  logic              ren_valid_q;
  logic [31:0]       rdata_hold;

  logic              new_cmd;
  logic              cpu_pending;
  op_t               new_op;
  op_t               req_op;
  logic              grant_cpu;
  logic              grant_ren;
  logic [31:0]       done_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [ATTR_W-1:0] ram_wdata;
  logic [ATTR_W-1:0] ram_rdata;

  // A pulse arriving while idle competes for the grant in its own cycle.
  assign new_cmd     = (cpu_re | cpu_we) & ~pend_valid;
  assign cpu_pending = pend_valid | new_cmd;
  assign new_op      = decode_op(cpu_we, cpu_action);
  assign req_op      = pend_valid ? pend_op : new_op;
  assign done_rdata  = (pend_op == OP_READ) ? {{(32-ATTR_W){1'b0}}, ram_rdata} : 32'd0;

  assign cpu_busy  = pend_valid;
  assign cpu_done  = (state == ST_DONE);
  assign cpu_rdata = (state == ST_DONE) ? done_rdata : rdata_hold;
  assign ren_gnt   = grant_ren;
  assign ren_valid = ren_valid_q;
  assign ren_rdata = ren_valid_q ? ram_rdata : '0;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, arbitration and RAM port control.
  always_comb begin
    state_nxt = state;
    grant_cpu = 1'b0;
    grant_ren = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = {pend_addr, pend_attr};
    ram_wdata = pend_wdata;
    case (state)
      ST_IDLE: begin
        // The renderer is held off for the first cycle after reset so
        // that ren_gnt cannot follow ren_req while rst_n is low.
        if (cpu_pending && (!ren_req || !out_of_reset || last_ren)) begin
          grant_cpu = 1'b1;
        end else if (ren_req && out_of_reset) begin
          grant_ren = 1'b1;
        end
        if (grant_cpu) begin
          state_nxt = (req_op == OP_CLEAR) ? ST_CLEAR : ST_ACCESS;
        end
        if (grant_ren) begin
          ram_en   = 1'b1;
          ram_addr = {ren_addr, ren_attr[IDX_W-1:0]};
        end
      end
      ST_ACCESS: begin
        if (pend_op == OP_WRITE) begin
          ram_en = 1'b1;
          ram_we = 1'b1;
        end else if (pend_op == OP_READ || pend_op == OP_MOVE) begin
          ram_en = 1'b1;
        end
        state_nxt = (pend_op == OP_MOVE) ? ST_RMW_WR : ST_DONE;
      end
      ST_RMW_WR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_wdata = ram_rdata + pend_wdata;
        state_nxt = ST_DONE;
      end
      ST_CLEAR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = {pend_addr, clr_cnt};
        ram_wdata = '0;
        if (clr_cnt == IDX_W'(NUM_ATTR - 1)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Capture a CPU command into the pending register; release it on done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_op    <= OP_NOP;
      pend_addr  <= '0;
      pend_attr  <= '0;
      pend_wdata <= '0;
    end else if (state == ST_DONE) begin
      pend_valid <= 1'b0;
    end else if (new_cmd) begin
      pend_valid <= 1'b1;
      pend_op    <= new_op;
      pend_addr  <= cpu_addr;
      pend_wdata <= cpu_wdata;
      if (new_op == OP_MOVE) begin
        pend_attr <= (cpu_action == ACT_MOVE_Y) ? IDX_W'(1) : '0;
      end else begin
        pend_attr <= cpu_action[IDX_W-1:0];
      end
    end
  end

  // Round-robin pointer; starts on the renderer so the CPU wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ren <= 1'b1;
    end else if (grant_cpu) begin
      last_ren <= 1'b0;
    end else if (grant_ren) begin
      last_ren <= 1'b1;
    end
  end

  // Marks that at least one clock edge has passed since reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_of_reset <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
    end
  end

  // Attribute index walked by the clear sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
    end else begin
      clr_cnt <= '0;
    end
  end

  // Renderer data is valid the cycle after its grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ren_valid_q <= 1'b0;
    end else begin
      ren_valid_q <= grant_ren;
    end
  end

  // Hold the last CPU result until the next done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_hold <= '0;
    end else if (state == ST_DONE) begin
      rdata_hold <= done_rdata;
    end
  end

  sprite_attr_ram #(
    .ATTR_W (ATTR_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule
